// File: rtl/aes_state_bcd_scanner.sv
// aes_state_bcd_scanner
//   Display stage for the AES self-test. Accepts one 128-bit block over a
//   valid/ready handshake. Walks its 16 bytes, MSB byte first, and converts
//   each byte to three BCD digits with a bit-serial shift-add-3 (double-dabble)
//   engine. Each result is held on the digit outputs for DWELL enabled cycles.
//
// Parameters
//   DWELL        clk cycles each converted byte stays displayed (>= 1)
//   CNT_W        width of the dwell counter (must hold DWELL)
//
// Ports
//   clk          clock
//   reset        synchronous, active-high reset
//   enable       dwell counter advances only while high
//   in_valid     in_block is valid
//   in_ready     block accepted when in_valid && in_ready at a rising edge
//   in_block     [0:127] block; byte k = in_block[8k +: 8], byte 0 = bits [0:7]
//   units        BCD ones digit of the current byte
//   tens         BCD tens digit
//   hunds        BCD hundreds digit (0..2)
//   byte_idx     index of the byte currently shown / being converted
//   digits_valid digits hold a completed conversion of byte_idx
//   busy         high in any state other than IDLE
//   done         one-cycle pulse after byte 15's dwell ends
module aes_state_bcd_scanner #(
    parameter int DWELL = 1000,
    parameter int CNT_W = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         enable,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [0:127] in_block,
    output logic [3:0]   units,
    output logic [3:0]   tens,
    output logic [3:0]   hunds,
    output logic [3:0]   byte_idx,
    output logic         digits_valid,
    output logic         busy,
    output logic         done
);

    typedef enum logic [1:0] {
        IDLE,
        CONV,
        HOLD
    } state_t;

    localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL - 1);

    state_t           state;
    state_t           nextState;

    // Byte currently being converted / shown always sits in blockReg[127:120];
    // the register shifts left by one byte each time the scan advances.
    logic [127:0]     blockReg;
    // {hunds, tens, units, byte} working register of the double-dabble engine.
    logic [19:0]      shiftReg;
    logic [19:0]      stepped;
    logic [2:0]       bitCnt;
    logic [CNT_W-1:0] dwellCnt;

    logic             accept;
    logic             convLast;
    logic             dwellEnd;
    logic             lastByte;

    // Add 3 to a BCD nibble that would overflow past 9 after the next doubling.
    function automatic logic [3:0] add3(input logic [3:0] n);
        return (n >= 4'd5) ? n + 4'd3 : n;
    endfunction

    // One double-dabble iteration: correct the three BCD nibbles, then shift.
    // Bit 19 is never set for 8-bit inputs, so dropping it loses nothing.
    function automatic logic [19:0] dabbleStep(input logic [19:0] r);
        logic [19:0] adj;
        adj = {add3(r[19:16]), add3(r[15:12]), add3(r[11:8]), r[7:0]};
        return {adj[18:0], 1'b0};
    endfunction

    assign accept   = (state == IDLE) && in_valid;
    assign stepped  = dabbleStep(shiftReg);
    assign convLast = (bitCnt == 3'd7);
    assign dwellEnd = enable && (dwellCnt == DWELL_LAST);
    assign lastByte = (byte_idx == 4'd15);

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    always_comb begin
        nextState = state;
        in_ready  = 1'b0;
        busy      = 1'b1;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                busy     = 1'b0;
                if (accept) begin
                    nextState = CONV;
                end
            end
            CONV: begin
                if (convLast) begin
                    nextState = HOLD;
                end
            end
            HOLD: begin
                if (dwellEnd) begin
                    nextState = lastByte ? IDLE : CONV;
                end
            end
            default: begin
                nextState = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            blockReg     <= '0;
            shiftReg     <= '0;
            bitCnt       <= '0;
            dwellCnt     <= '0;
            units        <= '0;
            tens         <= '0;
            hunds        <= '0;
            byte_idx     <= '0;
            digits_valid <= 1'b0;
            done         <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    // Digits from the previous scan stay visible until a new
                    // block is accepted.
                    if (accept) begin
                        blockReg     <= in_block;
                        shiftReg     <= {12'd0, in_block[0:7]};
                        bitCnt       <= '0;
                        byte_idx     <= '0;
                        digits_valid <= 1'b0;
                    end
                end
                CONV: begin
                    shiftReg <= stepped;
                    bitCnt   <= bitCnt + 3'd1;
                    // Outputs update only once the eighth bit has been absorbed.
                    if (convLast) begin
                        hunds        <= stepped[19:16];
                        tens         <= stepped[15:12];
                        units        <= stepped[11:8];
                        digits_valid <= 1'b1;
                        dwellCnt     <= '0;
                    end
                end
                HOLD: begin
                    if (enable) begin
                        if (dwellCnt == DWELL_LAST) begin
                            if (!lastByte) begin
                                byte_idx     <= byte_idx + 4'd1;
                                digits_valid <= 1'b0;
                                blockReg     <= blockReg << 8;
                                shiftReg     <= {12'd0, blockReg[119:112]};
                                bitCnt       <= '0;
                            end else begin
                                done <= 1'b1;
                            end
                        end else begin
                            dwellCnt <= dwellCnt + CNT_W'(1);
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_aes_state_bcd_scanner.sv
module tb_aes_state_bcd_scanner;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Instance with DWELL=4
    logic         rst4, en4, iv4, rdy4, dv4, busy4, done4;
    logic [127:0] blk4;
    logic [3:0]   u4, t4, h4, idx4;

    // Instance with DWELL=1
    logic         rst1, en1, iv1, rdy1, dv1, busy1, done1;
    logic [127:0] blk1;
    logic [3:0]   u1, t1, h1, idx1;

    aes_state_bcd_scanner #(.DWELL(4), .CNT_W(8)) dut4 (
        .clk(clk), .reset(rst4), .enable(en4), .in_valid(iv4), .in_ready(rdy4),
        .in_block(blk4), .units(u4), .tens(t4), .hunds(h4), .byte_idx(idx4),
        .digits_valid(dv4), .busy(busy4), .done(done4)
    );

    aes_state_bcd_scanner #(.DWELL(1), .CNT_W(4)) dut1 (
        .clk(clk), .reset(rst1), .enable(en1), .in_valid(iv1), .in_ready(rdy1),
        .in_block(blk1), .units(u1), .tens(t1), .hunds(h1), .byte_idx(idx1),
        .digits_valid(dv1), .busy(busy1), .done(done1)
    );

    localparam logic [19:0] RST_VEC = 20'h80000; // {in_ready,busy,done,dv,idx,h,t,u}

    int nTests = 0;
    int nFail  = 0;

    logic [15:0] q4[$];
    logic [15:0] q1[$];
    int          riseCyc4[16];
    int          doneCnt4 = 0;
    logic        prevDv4 = 1'b0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nTests++;
        if (obs !== exp) begin
            nFail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Expected {idx, hunds, tens, units} for one byte, from plain decimal division.
    function automatic logic [15:0] expByte(input logic [3:0] idx, input logic [7:0] v);
        int iv;
        iv = int'(v);
        return {idx, 4'(iv / 100), 4'((iv / 10) % 10), 4'(iv % 10)};
    endfunction

    task automatic pushBlock4(input logic [127:0] b);
        for (int k = 0; k < 16; k++) q4.push_back(expByte(4'(k), b[127-8*k -: 8]));
    endtask

    // Scoreboard monitor for the DWELL=4 instance: pops on each new display.
    always @(negedge clk) begin
        if (dv4 && !prevDv4) begin
            if (q4.size() == 0) begin
                chk("sb4 unexpected display", 64'(q4.size()), 64'd1);
            end else begin
                chk($sformatf("sb4 byte%0d", idx4), 64'({idx4, h4, t4, u4}), 64'(q4.pop_front()));
            end
            chk("sb4 bcd legal", 64'((h4 <= 4'd9) && (t4 <= 4'd9) && (u4 <= 4'd9)), 64'd1);
            riseCyc4[idx4] <= cyc;
        end
        if (done4) doneCnt4 <= doneCnt4 + 1;
        prevDv4 <= dv4;
    end

    task automatic sendBlock4(input logic [127:0] b, input bit keep, output int hs);
        iv4  = 1'b1;
        blk4 = b;
        for (int i = 0; i < 400 && !rdy4; i++) @(negedge clk);
        chk("send4 ready", 64'(rdy4), 64'd1);
        hs = cyc + 1;
        pushBlock4(b);
        @(negedge clk);
        if (!keep) iv4 = 1'b0;
    endtask

    task automatic waitDone4(input int bound, output int dc);
        int i;
        i = 0;
        while (!done4 && i < bound) begin
            @(negedge clk);
            i++;
        end
        chk("done4 seen", 64'(done4), 64'd1);
        dc = cyc;
    endtask

    task automatic sendBlock1(input logic [127:0] b, output int hs);
        iv1  = 1'b1;
        blk1 = b;
        for (int i = 0; i < 400 && !rdy1; i++) @(negedge clk);
        chk("send1 ready", 64'(rdy1), 64'd1);
        hs = cyc + 1;
        q1.push_back(expByte(4'd0, b[127:120]));
        @(negedge clk);
        iv1 = 1'b0;
    endtask

    task automatic waitDv1(input int bound);
        int i;
        i = 0;
        while (!dv1 && i < bound) begin
            @(negedge clk);
            i++;
        end
        chk("dv1 seen", 64'(dv1), 64'd1);
    endtask

    task automatic pulseRst1();
        rst1 = 1'b1;
        @(negedge clk);
        rst1 = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int hs, dc, e, dcnt;
        rst4 = 1'b1; rst1 = 1'b1; en4 = 1'b1; en1 = 1'b1;
        iv4 = 1'b0; iv1 = 1'b0; blk4 = '0; blk1 = '0;
        repeat (3) @(negedge clk);
        chk("reset4 outputs", 64'({rdy4, busy4, done4, dv4, idx4, h4, t4, u4}), 64'(RST_VEC));
        chk("reset1 outputs", 64'({rdy1, busy1, done1, dv1, idx1, h1, t1, u1}), 64'(RST_VEC));
        rst4 = 1'b0; rst1 = 1'b0;
        @(negedge clk);

        // Full scan of the reference block
        sendBlock4(128'h00112233445566778899aabbccddeeff, 1'b0, hs);
        waitDone4(400, dc);
        chk("t1 first latency", 64'(riseCyc4[0] - hs), 64'd8);
        chk("t1 done time", 64'(dc - hs), 64'd192);
        for (int k = 0; k < 15; k++)
            chk($sformatf("t1 period byte%0d", k), 64'(riseCyc4[k+1] - riseCyc4[k]), 64'd12);
        chk("t1 final state", 64'({idx4, dv4, rdy4, busy4, h4, t4, u4}),
            64'({4'hF, 1'b1, 1'b1, 1'b0, 12'h255}));
        @(negedge clk);
        chk("t1 done one cycle", 64'({done4, h4, t4, u4}), 64'({1'b0, 12'h255}));
        chk("t1 sb drained", 64'(q4.size()), 64'd0);

        // in_valid held high with in_block changing during the scan
        sendBlock4(128'hdeadbeef_0123_4567_89ab_cdef_fedc_ba98, 1'b1, hs);
        for (int i = 0; i < 300 && !done4; i++) begin
            @(negedge clk);
            if (!done4) begin
                blk4 = {$urandom(), $urandom(), $urandom(), $urandom()};
                if (i % 40 == 7) chk("t3 ready low while busy", 64'(rdy4), 64'd0);
            end
        end
        chk("t3 done seen", 64'(done4), 64'd1);
        chk("t3 done time", 64'(cyc - hs), 64'd192);
        chk("t3 ready in done cycle", 64'(rdy4), 64'd1);
        blk4 = 128'h0f1e2d3c4b5a69788796a5b4c3d2e1f0;
        hs = cyc + 1;
        pushBlock4(blk4);
        @(negedge clk);
        chk("t3 second accepted", 64'({busy4, rdy4, dv4}), 64'(3'b100));
        waitDone4(400, dc);
        iv4 = 1'b0;
        chk("t3 second done time", 64'(dc - hs), 64'd192);
        @(negedge clk);
        chk("t3 idle after", 64'(busy4), 64'd0);
        chk("t3 sb drained", 64'(q4.size()), 64'd0);

        // enable dropped for 10 cycles in the HOLD of byte 3
        sendBlock4(128'h80c0e0f0f8fcfeff7f3f1f0f07030100, 1'b0, hs);
        for (int i = 0; i < 100 && !(dv4 && idx4 == 4'd3); i++) @(negedge clk);
        e = cyc;
        en4 = 1'b0;
        repeat (10) @(negedge clk);
        chk("t4 frozen on byte3", 64'({idx4, dv4}), 64'({4'd3, 1'b1}));
        en4 = 1'b1;
        waitDone4(400, dc);
        chk("t4 done time", 64'(dc - hs), 64'd202);
        chk("t4 byte3 to byte2", 64'(e - riseCyc4[2]), 64'd12);
        chk("t4 byte4 after byte3", 64'(riseCyc4[4] - e), 64'd22);
        chk("t4 byte5 after byte4", 64'(riseCyc4[5] - riseCyc4[4]), 64'd12);
        @(negedge clk);

        // reset during the CONV of byte 5
        sendBlock4(128'h11223344556677889900aabbccddeeff, 1'b0, hs);
        for (int i = 0; i < 200 && !(idx4 == 4'd5 && !dv4 && busy4); i++) @(negedge clk);
        chk("t5 in conv of byte5", 64'({idx4, dv4, busy4}), 64'({4'd5, 1'b0, 1'b1}));
        dcnt = doneCnt4;
        rst4 = 1'b1;
        @(negedge clk);
        rst4 = 1'b0;
        chk("t5 reset outputs", 64'({rdy4, busy4, done4, dv4, idx4, h4, t4, u4}), 64'(RST_VEC));
        q4.delete();
        repeat (250) @(negedge clk);
        chk("t5 no done pulse", 64'(doneCnt4), 64'(dcnt));
        chk("t5 stays idle", 64'({busy4, rdy4}), 64'(2'b01));
        sendBlock4(128'h9988776655443322110099887766554f, 1'b0, hs);
        waitDone4(400, dc);
        chk("t5 rescan first latency", 64'(riseCyc4[0] - hs), 64'd8);
        chk("t5 rescan done time", 64'(dc - hs), 64'd192);
        chk("t5 sb drained", 64'(q4.size()), 64'd0);

        // DWELL=1: byte 0 = 0xFF
        sendBlock1(128'hff01020304050607_08090a0b0c0d0e0f, hs);
        waitDv1(20);
        chk("t6 latency", 64'(cyc - hs), 64'd8);
        chk("t6 digits", 64'({idx1, h1, t1, u1}), 64'(q1.pop_front()));
        @(negedge clk);
        chk("t6 held one cycle", 64'({dv1, idx1}), 64'({1'b0, 4'd1}));
        pulseRst1();

        // Sweep every byte value in byte 0
        for (int v = 0; v < 256; v++) begin
            sendBlock1({8'(v), $urandom(), $urandom(), $urandom(), 24'($urandom())}, hs);
            waitDv1(20);
            chk($sformatf("sweep %0d digits", v), 64'({idx1, h1, t1, u1}), 64'(q1.pop_front()));
            chk($sformatf("sweep %0d value", v), 64'(int'(h1) * 100 + int'(t1) * 10 + int'(u1)), 64'(v));
            chk($sformatf("sweep %0d legal", v), 64'((h1 <= 4'd2) && (t1 <= 4'd9) && (u1 <= 4'd9)), 64'd1);
            pulseRst1();
        end

        $display("[TB] %0d tests run, %0d failed", nTests, nFail);
        $finish;
    end

endmodule
